seg7_scan_ctrl: RTL and testbench
=================================

// Module: seg7_scan_ctrl
// PURPOSE
//  Parametrised multiplexed 7-segment display controller; successor to the single-digit hex decoder.
//  Drives DIGITS common-anode digits from one shared segment bus by time-division scanning.
//  Adds per-digit point, blanking and blink, anti-ghost dead time, and tear-free frame-synchronous update.
//  Sits between CPU/IO register outputs and the board display pins.
// PARAMETERS
//  DIGITS     8      number of digits scanned (1..16)
//  SCAN_DIV   50000  clk cycles per digit slot (>= DEAD+2)
//  DEAD       16     cycles at slot start with all anodes off (0 = no dead time)
//  BLINK_DIV  64     frames per blink half-period (>= 1)
// PORTS
//  clk        in   1          system clock; single clock domain
//  rst        in   1          synchronous reset, active-high
//  load       in   1          1-cycle strobe: capture data/point/blank/blink_en
//  data       in   4*DIGITS   hex nibble per digit; digit i = data[4i+3:4i]
//  point      in   DIGITS     decimal point on, per digit (1 = lit)
//  blank      in   DIGITS     digit blanked, per digit (1 = all segments and point off)
//  blink_en   in   DIGITS     digit blinks at blink rate, per digit
//  pending    out  1          captured value is waiting for the next frame boundary
//  seg_n      out  8          {a,b,c,d,e,f,g,p}, active-low
//  an_n       out  DIGITS     digit enables, active-low; at most one low
//  frame_tick out  1          1-cycle pulse when digit 0 slot begins
// BEHAVIOUR
//  - Reset (rst=1 at posedge): seg_n=8'hFF, an_n=all 1, frame_tick=0, pending=0.
//  - Reset also clears: slot counter cnt=0, digit index idx=0, blink phase ph=0, blink frame count=0,
//    and the pending/display registers (data=0, point=0, blank=all 1, blink_en=0).
//    Reset mid-operation aborts any pending load.
//  - cnt counts 0..SCAN_DIV-1.
//  - At cnt=SCAN_DIV-1: cnt wraps to 0 and idx advances; idx wraps from DIGITS-1 to 0.
//  - Frame boundary = cycle where cnt and idx both wrap (idx DIGITS-1 -> 0).
//  - Blink: a frame counter counts boundaries. Every BLINK_DIV boundaries, ph toggles and the counter clears.
//  - Outputs are registered: the value driven in cycle n+1 is computed from state in cycle n (1-cycle latency).
//  - Anode output an_n:
//      all 1 while cnt < DEAD;
//      otherwise only an_n[idx]=0.
//  - Segment output seg_n:
//      all 1 (8'hFF) when cnt < DEAD, or blank[idx]=1, or (blink_en[idx]=1 and ph=1);
//      otherwise {a..g} = decode(data[idx]) and p = ~point[idx].
//  - Decode table (a..g, active-low), hex 0..F:
//      0:0000001  1:1001111  2:0010010  3:0000110
//      4:1001100  5:0100100  6:0100000  7:0001111
//      8:0000000  9:0000100  A:0001000  b:1100000
//      C:0110001  d:1000010  E:0110000  F:0111000
//  - frame_tick goes high in the cycle after a frame boundary, aligned with the first cycle of the idx=0 slot.
//  - Load/update handshake:
//      load=1 copies inputs into the pending register and sets pending=1 in the next cycle.
//      At a frame boundary with pending=1, pending is copied to the display register and pending clears.
//      The display never changes mid-frame (no tearing).
//      load during pending=1 overwrites the pending value (last write wins); only one transfer occurs.
//      load in the same cycle as a boundary: the inputs go straight to the display register; pending stays 0.
//  - Widths:
//      cnt width = $clog2(SCAN_DIV); idx width = max(1, $clog2(DIGITS)).
//      Blink frame counter width = max(1, $clog2(BLINK_DIV)).
//      DIGITS=1: idx is constant 0 and every slot end is a frame boundary.
// STRUCTURE
//  - Shared package seg7_pkg:
//      SEG_BLANK = 8'hFF, the 16-entry decode constant table, and function hex2seg(nibble) -> 7 bits.
//  - One sub-module, hex7_decode (combinational nibble + point -> 8-bit active-low segments);
//    instantiated once on the muxed digit.
//  - Top level holds cnt, idx, blink frame counter/ph, the pending and display registers, and the output registers.
// TESTING (DIGITS=4, SCAN_DIV=8, DEAD=2, BLINK_DIV=2)
//  1. Hold rst 3 cycles, then release.
//     -> seg_n=FF and an_n=F during reset.
//     -> After first frame, all digits stay blanked until the first load.
//  2. load data=16'h3A10, point=4'b0100, blank=0, blink_en=0.
//     -> Display changes at the next boundary (not before); pending high until then.
//     -> Slot idx0: an_n=1110, seg_n=0000_0011.
//     -> Slot idx1: an_n=1101, seg_n=1001_1111.
//     -> Slot idx2: an_n=1011, seg_n=0001_0000 (A with point lit).
//     -> Slot idx3: an_n=0111, seg_n=0000_1101.
//  3. Dead time: first 2 cycles of every slot have an_n=1111 and seg_n=FF.
//     -> No cycle ever has two anodes low.
//  4. blink_en=4'b0001, BLINK_DIV=2.
//     -> Digit 0 is lit for 2 frames, dark for 2 frames, and repeats; digits 1-3 stay lit.
//     -> frame_tick pulses once every 32 cycles.
//  5. Simultaneous events:
//     -> Two loads in one frame: only the second value is ever displayed.
//     -> load on the boundary cycle: new value shown in that frame, pending stays 0.
//  6. Assert rst mid-frame with pending=1.
//     -> Next cycle: outputs FF/F, pending=0; scanning restarts at idx0, cnt0.

Source files
------------

// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants and helpers for the multiplexed 7-segment display path.
//   SEG_BLANK      : active-low segment word with every segment and point off
//   HEX2SEG_TABLE  : hex nibble -> {a,b,c,d,e,f,g}, active-low
//   hex2seg()      : table lookup wrapper used by the digit decoder
// -----------------------------------------------------------------------------
package seg7_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Index is the nibble value; bit 6 is segment a, bit 0 is segment g.
  localparam logic [6:0] HEX2SEG_TABLE [16] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100,  // 9
    7'b0001000,  // A
    7'b1100000,  // b
    7'b0110001,  // C
    7'b1000010,  // d
    7'b0110000,  // E
    7'b0111000   // F
  };

  function automatic logic [6:0] hex2seg(input logic [3:0] nibble);
    return HEX2SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/hex7_decode.sv
// -----------------------------------------------------------------------------
// hex7_decode
// Combinational decoder: one hex nibble plus decimal point to an active-low
// segment word {a,b,c,d,e,f,g,p}.
//   nibble_i : hex digit value
//   point_i  : 1 = decimal point lit
//   seg_n_o  : active-low segments, point in bit 0
// -----------------------------------------------------------------------------
module hex7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       point_i,
  output logic [7:0] seg_n_o
);

  assign seg_n_o = {hex2seg(nibble_i), ~point_i};

endmodule

// File: rtl/seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_scan_ctrl
// Time-division scanner for DIGITS common-anode digits sharing one segment bus.
// Each digit owns a slot of SCAN_DIV cycles; the first DEAD cycles of a slot
// keep every anode off so the previous digit's pattern cannot ghost into the
// next one. New content is captured into a pending register by 'load' and only
// moved into the display register at a frame boundary, so a frame never shows
// a mix of old and new digits.
//   clk        : system clock
//   rst        : synchronous reset, active-high
//   load       : 1-cycle strobe capturing data/point/blank/blink_en
//   data       : hex nibble per digit, digit i = data[4i+3:4i]
//   point      : decimal point per digit (1 = lit)
//   blank      : digit blanked (1 = segments and point off)
//   blink_en   : digit blinks with the blink phase
//   pending    : captured value waiting for the next frame boundary
//   seg_n      : {a,b,c,d,e,f,g,p}, active-low, registered
//   an_n       : digit enables, active-low, at most one low, registered
//   frame_tick : 1-cycle pulse on the first cycle of the digit-0 slot
// -----------------------------------------------------------------------------
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIGITS    = 8,
  parameter int SCAN_DIV  = 50000,
  parameter int DEAD      = 16,
  parameter int BLINK_DIV = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     point,
  input  logic [DIGITS-1:0]     blank,
  input  logic [DIGITS-1:0]     blink_en,
  output logic                  pending,
  output logic [7:0]            seg_n,
  output logic [DIGITS-1:0]     an_n,
  output logic                  frame_tick
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEAD_CYC   = CW'(DEAD);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  // Everything 'load' captures, kept together so pending and display move as one.
  typedef struct packed {
    logic [DIGITS-1:0][3:0] data;
    logic [DIGITS-1:0]      point;
    logic [DIGITS-1:0]      blank;
    logic [DIGITS-1:0]      blink;
  } frame_t;

  localparam frame_t FRAME_RESET = '{data: '0, point: '0, blank: '1, blink: '0};

  // Scan and blink state
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          ph_q, ph_d;

  // Update handshake
  frame_t        pend_q, pend_d;
  frame_t        disp_q, disp_d;
  logic          pending_q, pending_d;

  // Registered outputs
  logic [7:0]        seg_n_q, seg_n_d;
  logic [DIGITS-1:0] an_n_q, an_n_d;
  logic              frame_tick_q, frame_tick_d;

  logic   slot_end;
  logic   boundary;
  logic   dead;
  frame_t in_frame;
  logic [7:0] dec_seg_n;

  assign slot_end = (cnt_q == CNT_LAST);
  assign boundary = slot_end && (idx_q == IDX_LAST);
  assign dead     = (cnt_q < DEAD_CYC);
  assign in_frame = '{data: data, point: point, blank: blank, blink: blink_en};

  // ---------------------------------------------------------------------------
  // Scan counters and blink phase
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and a latch cannot be inferred.
    cnt_d  = cnt_q + 1'b1;
    idx_d  = idx_q;
    bcnt_d = bcnt_q;
    ph_d   = ph_q;

    if (slot_end) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    if (boundary) begin
      if (bcnt_q == BLINK_LAST) begin
        bcnt_d = '0;
        ph_d   = ~ph_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pending / display handshake. A load coinciding with a boundary bypasses
  // the pending register so it is shown in the frame that starts next.
  // ---------------------------------------------------------------------------
  always_comb begin
    pend_d    = pend_q;
    disp_d    = disp_q;
    pending_d = pending_q;

    if (boundary) begin
      if (load) begin
        disp_d    = in_frame;
        pending_d = 1'b0;
      end else if (pending_q) begin
        disp_d    = pend_q;
        pending_d = 1'b0;
      end
    end else if (load) begin
      pend_d    = in_frame;
      pending_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output next-state: one decoder on the currently selected digit.
  // ---------------------------------------------------------------------------
  hex7_decode u_dec (
    .nibble_i (disp_q.data[idx_q]),
    .point_i  (disp_q.point[idx_q]),
    .seg_n_o  (dec_seg_n)
  );

  always_comb begin
    an_n_d = '1;
    if (!dead) begin
      an_n_d[idx_q] = 1'b0;
    end

    if (dead || disp_q.blank[idx_q] || (disp_q.blink[idx_q] && ph_q)) begin
      seg_n_d = SEG_BLANK;
    end else begin
      seg_n_d = dec_seg_n;
    end

    frame_tick_d = boundary;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      bcnt_q       <= '0;
      ph_q         <= 1'b0;
      pending_q    <= 1'b0;
      // NOTE: the pending/display registers are reset, not left uninitialised,
      // because the display must come up blanked rather than showing garbage.
      pend_q       <= FRAME_RESET;
      disp_q       <= FRAME_RESET;
      seg_n_q      <= SEG_BLANK;
      an_n_q       <= '1;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      bcnt_q       <= bcnt_d;
      ph_q         <= ph_d;
      pending_q    <= pending_d;
      pend_q       <= pend_d;
      disp_q       <= disp_d;
      seg_n_q      <= seg_n_d;
      an_n_q       <= an_n_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign pending    = pending_q;
  assign seg_n      = seg_n_q;
  assign an_n       = an_n_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_ctrl
// Scoreboard bench for seg7_scan_ctrl with DIGITS=4, SCAN_DIV=8, DEAD=2,
// BLINK_DIV=2. Expected per-slot {an_n, seg_n} words are pushed when a frame's
// content is known and popped as each slot is observed.
// Output cycle k after frame_tick (k=0 is the tick cycle) shows slot k/8 at
// in-slot count (k%8)-1, so k%8 in {1,2} is dead time and 3..7 is lit.
// -----------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

  localparam int ND    = 4;
  localparam int SD    = 8;
  localparam int DT    = 2;
  localparam int BD    = 2;
  localparam int FRAME = ND * SD;

  localparam logic [6:0] TB_DEC [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  point;
    logic [3:0]  blank;
    logic [3:0]  blink;
  } ld_t;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] seg;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] data;
  logic [3:0]  point;
  logic [3:0]  blank;
  logic [3:0]  blink_en;
  logic        pending;
  logic [7:0]  seg_n;
  logic [3:0]  an_n;
  logic        frame_tick;

  exp_t sb_q[$];
  int   n_checks   = 0;
  int   n_pass     = 0;
  int   onehot_err = 0;

  ld_t v_none  = '0;
  ld_t v_blank = '{data: 16'h0000, point: 4'b0000, blank: 4'b1111, blink: 4'b0000};
  ld_t v_a     = '{data: 16'h3A10, point: 4'b0100, blank: 4'b0000, blink: 4'b0000};
  ld_t v_b     = '{data: 16'hBEEF, point: 4'b1111, blank: 4'b0000, blink: 4'b0000};
  ld_t v_c     = '{data: 16'h5C7D, point: 4'b1001, blank: 4'b0010, blink: 4'b0000};
  ld_t v_d     = '{data: 16'h9842, point: 4'b0000, blank: 4'b0000, blink: 4'b0000};
  ld_t v_bl    = '{data: 16'h6F2E, point: 4'b0001, blank: 4'b0000, blink: 4'b0001};
  ld_t v_e     = '{data: 16'h1234, point: 4'b1111, blank: 4'b0000, blink: 4'b0000};

  seg7_scan_ctrl #(
    .DIGITS    (ND),
    .SCAN_DIV  (SD),
    .DEAD      (DT),
    .BLINK_DIV (BD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .data       (data),
    .point      (point),
    .blank      (blank),
    .blink_en   (blink_en),
    .pending    (pending),
    .seg_n      (seg_n),
    .an_n       (an_n),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Two anodes low at once would light two digits with one pattern.
  always @(negedge clk) begin
    if (rst === 1'b0 && $countones(~an_n) > 1) onehot_err++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish by 100000 ns");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Model and helpers
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] model_seg(input ld_t v, input int j, input bit ph);
    logic [3:0] nib;
    nib = v.data[4*j +: 4];
    if (v.blank[j] || (v.blink[j] && ph)) return 8'hFF;
    return {TB_DEC[nib], ~v.point[j]};
  endfunction

  task automatic push_frame(input ld_t v, input bit ph);
    for (int j = 0; j < ND; j++) begin
      exp_t e;
      e.an  = ~(4'b0001 << j);
      e.seg = model_seg(v, j, ph);
      sb_q.push_back(e);
    end
  endtask

  task automatic apply(input ld_t v);
    data     = v.data;
    point    = v.point;
    blank    = v.blank;
    blink_en = v.blink;
  endtask

  // Returns at the negedge where frame_tick is high; n = negedges waited.
  task automatic wait_tick(output int n);
    n = 0;
    for (int i = 1; i <= 3 * FRAME; i++) begin
      @(negedge clk);
      load = 1'b0;
      if (frame_tick === 1'b1) begin
        n = i;
        return;
      end
    end
    n_checks++;
    $display("FAIL frame_tick_timeout: got no pulse in %0d cycles, required one", 3 * FRAME);
  endtask

  // Observe one full frame against four scoreboard entries; optionally
  // strobe load at output cycles lk1/lk2 (-1 = none).
  task automatic observe_frame(input int lk1, input ld_t v1, input int lk2, input ld_t v2,
                               input int exp_pend0);
    int   n;
    exp_t e;
    e = 'x;
    wait_tick(n);
    if (exp_pend0 >= 0) begin
      n_checks++;
      if (pending !== exp_pend0[0])
        $display("FAIL pending_at_frame_start: got %b, required %b", pending, exp_pend0[0]);
      else n_pass++;
    end
    for (int k = 1; k < FRAME; k++) begin
      @(negedge clk);
      load = 1'b0;
      if (k == lk1) begin apply(v1); load = 1'b1; end
      if (k == lk2) begin apply(v2); load = 1'b1; end
      if (lk1 >= 0 && lk1 < FRAME - 1 && (k == lk1 + 1 || k == FRAME - 1)) begin
        n_checks++;
        if (pending !== 1'b1)
          $display("FAIL pending_held k=%0d: got %b, required 1", k, pending);
        else n_pass++;
      end
      if (k % SD == 1 || k % SD == 2) begin
        n_checks++;
        if ({an_n, seg_n} !== {4'hF, 8'hFF})
          $display("FAIL dead_time k=%0d: got an_n=%b seg_n=%b, required an_n=1111 seg_n=11111111",
                   k, an_n, seg_n);
        else n_pass++;
      end
      if (k % SD == 3) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          e = 'x;
          $display("FAIL scoreboard_empty k=%0d: got no expected entry, required one", k);
        end else begin
          e = sb_q.pop_front();
        end
      end
      if (k % SD == 3 || k % SD == 7) begin
        n_checks++;
        if ({an_n, seg_n} !== e)
          $display("FAIL slot%0d k=%0d: got an_n=%b seg_n=%b, required an_n=%b seg_n=%b",
                   k / SD, k, an_n, seg_n, e.an, e.seg);
        else n_pass++;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({seg_n, an_n, pending, frame_tick} !== {8'hFF, 4'hF, 1'b0, 1'b0})
        $display("FAIL reset_outputs: got seg_n=%h an_n=%b pending=%b frame_tick=%b, required FF 1111 0 0",
                 seg_n, an_n, pending, frame_tick);
      else n_pass++;
    end
    rst = 1'b0;
    push_frame(v_blank, 1'b0);
    observe_frame(-1, v_none, -1, v_none, 0);
  endtask

  task automatic test_load_update();
    push_frame(v_blank, 1'b0);
    observe_frame(5, v_a, -1, v_none, 0);
    push_frame(v_a, 1'b0);
    observe_frame(-1, v_none, -1, v_none, 0);
  endtask

  task automatic test_frame_tick();
    int n;
    wait_tick(n);
    wait_tick(n);
    n_checks++;
    if (n !== FRAME)
      $display("FAIL frame_tick_period: got %0d cycles, required %0d", n, FRAME);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (frame_tick !== 1'b0)
      $display("FAIL frame_tick_width: got %b one cycle after pulse, required 0", frame_tick);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    push_frame(v_a, 1'b0);
    observe_frame(4, v_b, 20, v_c, 0);
    push_frame(v_c, 1'b0);
    observe_frame(-1, v_none, -1, v_none, 0);
  endtask

  task automatic test_load_on_boundary();
    push_frame(v_c, 1'b0);
    observe_frame(FRAME - 1, v_d, -1, v_none, 0);
    push_frame(v_d, 1'b0);
    observe_frame(-1, v_none, -1, v_none, 0);
  endtask

  task automatic test_blink();
    rst  = 1'b1;
    load = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    apply(v_bl);
    load = 1'b1;
    // Phase after reset: frames 0,1 phase 0; 2,3 phase 1; 4,5 phase 0.
    push_frame(v_bl, 1'b0);
    push_frame(v_bl, 1'b1);
    push_frame(v_bl, 1'b1);
    push_frame(v_bl, 1'b0);
    push_frame(v_bl, 1'b0);
    for (int f = 0; f < 5; f++) observe_frame(-1, v_none, -1, v_none, 0);
  endtask

  task automatic test_reset_mid_frame();
    int n;
    wait_tick(n);
    repeat (2) @(negedge clk);
    apply(v_e);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    n_checks++;
    if (pending !== 1'b1)
      $display("FAIL pending_before_reset: got %b, required 1", pending);
    else n_pass++;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({seg_n, an_n, pending, frame_tick} !== {8'hFF, 4'hF, 1'b0, 1'b0})
      $display("FAIL mid_reset_outputs: got seg_n=%h an_n=%b pending=%b frame_tick=%b, required FF 1111 0 0",
               seg_n, an_n, pending, frame_tick);
    else n_pass++;
    rst = 1'b0;
    wait_tick(n);
    n_checks++;
    if (n !== FRAME)
      $display("FAIL restart_alignment: got first tick after %0d cycles, required %0d", n, FRAME);
    else n_pass++;
    push_frame(v_blank, 1'b0);
    observe_frame(-1, v_none, -1, v_none, 0);
  endtask

  task automatic test_onehot();
    n_checks++;
    if (onehot_err !== 0)
      $display("FAIL anode_onehot: got %0d cycles with several anodes low, required 0", onehot_err);
    else n_pass++;
  endtask

  initial begin
    rst  = 1'b1;
    load = 1'b0;
    apply(v_none);
    test_reset();
    test_load_update();
    test_frame_tick();
    test_back_to_back();
    test_load_on_boundary();
    test_blink();
    test_reset_mid_frame();
    test_onehot();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
